// File: rtl/vp_pkg.sv
// Shared definitions for the variable-precision multiply/accumulate datapath.
// Mode encodings and product slot layout are common with the multiplier.
package vp_pkg;

  localparam int NLANES = 4;

  localparam logic [1:0] MODE_4B  = 2'b00;
  localparam logic [1:0] MODE_8B  = 2'b01;
  localparam logic [1:0] MODE_16B = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int LANES_4B       = 4;
  localparam int SLOT_STRIDE_4B = 16;
  localparam int SLOT_W_4B      = 8;

  localparam int LANES_8B       = 2;
  localparam int SLOT_STRIDE_8B = 16;
  localparam int SLOT_W_8B      = 16;

  localparam int SLOT_W_16B     = 32;

endpackage

// File: rtl/vp_lane_extract.sv
// Splits a packed product word into four zero-extended lane addends.
// Lanes a mode does not produce contribute zero.
module vp_lane_extract
  import vp_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [1:0]              mode_i,
  input  logic [63:0]             data_i,
  output logic [NLANES*ACC_W-1:0] add_o
);

  // Product slots never populated in any mode.
  logic unused_slots;
  assign unused_slots = ^{data_i[63:56], data_i[47:40]};

  always_comb begin
    add_o = '0;
    unique case (1'b1)
      (mode_i == MODE_4B): begin
        for (int i = 0; i < LANES_4B; i++) begin
          add_o[i*ACC_W +: ACC_W] =
            ACC_W'(data_i[i*SLOT_STRIDE_4B +: SLOT_W_4B]);
        end
      end
      (mode_i == MODE_8B): begin
        for (int i = 0; i < LANES_8B; i++) begin
          add_o[i*ACC_W +: ACC_W] =
            ACC_W'(data_i[i*SLOT_STRIDE_8B +: SLOT_W_8B]);
        end
      end
      (mode_i == MODE_16B): begin
        add_o[0 +: ACC_W] = ACC_W'(data_i[SLOT_W_16B-1:0]);
      end
      default: add_o = '0;
    endcase
  end

endmodule

// File: rtl/vp_accumulator.sv
// Per-lane saturating accumulation of packed products over a programmed
// number of beats, with a cross-lane total on a valid/ready result port.
module vp_accumulator
  import vp_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        len,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [63:0]             in_data,
  output logic                    in_ready,
  output logic                    drop,
  output logic                    busy,
  output logic                    err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANES*ACC_W-1:0] out_lanes,
  output logic [ACC_W+1:0]        out_total,
  output logic [1:0]              out_mode,
  output logic [NLANES-1:0]       out_ovf
);

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic [NLANES*ACC_W-1:0] lanes_q, lanes_d;
  logic [NLANES-1:0]       ovf_q, ovf_d;
  logic                    drop_q, drop_d;
  logic                    err_q, err_d;
  logic [NLANES*ACC_W-1:0] add;
  logic [ACC_W:0]          sum [NLANES];

  vp_lane_extract #(
    .ACC_W (ACC_W)
  ) u_extract (
    .mode_i (mode_q),
    .data_i (in_data),
    .add_o  (add)
  );

  // The extra top bit of each sum is the saturation carry.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      sum[i] = {1'b0, lanes_q[i*ACC_W +: ACC_W]}
             + {1'b0, add[i*ACC_W +: ACC_W]};
    end
  end

  always_comb begin
    out_total = '0;
    for (int i = 0; i < NLANES; i++) begin
      out_total = out_total
                + (ACC_W+2)'(lanes_q[i*ACC_W +: ACC_W]);
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    drop_d  = in_valid && (state_q != S_ACCUM);
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lanes_d = '0;
      ovf_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && (mode == MODE_ILL)) begin
            err_d = 1'b1;
          end else if (start) begin
            mode_d  = mode;
            len_d   = len;
            cnt_d   = '0;
            lanes_d = '0;
            ovf_d   = '0;
            state_d = (len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < NLANES; i++) begin
              if (sum[i][ACC_W]) begin
                lanes_d[i*ACC_W +: ACC_W] = '1;
                ovf_d[i] = 1'b1;
              end else begin
                lanes_d[i*ACC_W +: ACC_W] = sum[i][ACC_W-1:0];
              end
            end
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      lanes_q <= '0;
      ovf_q   <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign drop      = drop_q;
  assign err       = err_q;
  assign out_lanes = lanes_q;
  assign out_mode  = mode_q;
  assign out_ovf   = ovf_q;

endmodule
